// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file for the CPU datapath.
//   DEPTH x WIDTH storage, NREAD combinational read ports and two synchronous write ports.
//   Register 0 can be hardwired to zero. A bulk-clear engine zeroes one register per cycle.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset (clears the array and the clear engine)
//   WrEn0/Aw0/Dw0  write port 0 (enable, address, data)
//   WrEn1/Aw1/Dw1  write port 1; wins over port 0 when both hit the same address
//   Ar             packed read addresses, port i = Ar[i*AW +: AW]
//   Dr             packed read data,      port i = Dr[i*WIDTH +: WIDTH]
//   clr_req        starts a bulk clear; sampled only while idle
//   clr_busy       high while the clear engine runs (exactly DEPTH cycles)
//
// Configuration macro REGFILE_BYPASS_EN: when defined, a read whose address matches an accepted
// write in the same cycle returns the write data combinationally (port 1 has priority).
module register_file_mp #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WrEn0,
  input  logic [AW-1:0]          Aw0,
  input  logic [WIDTH-1:0]       Dw0,
  input  logic                   WrEn1,
  input  logic [AW-1:0]          Aw1,
  input  logic [WIDTH-1:0]       Dw1,
  input  logic [NREAD*AW-1:0]    Ar,
  output logic [NREAD*WIDTH-1:0] Dr,
  input  logic                   clr_req,
  output logic                   clr_busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Address maps to a real, writable register (also used to gate reads).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes are only accepted while idle; the clear engine owns the array otherwise.
  logic we0_ok, we1_ok;
  assign we0_ok = WrEn0 && (state_q == StIdle) && addr_ok(Aw0);
  assign we1_ok = WrEn1 && (state_q == StIdle) && addr_ok(Aw1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      clr_busy <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (we0_ok) mem_q[Aw0] <= Dw0;
          // Later assignment wins, so port 1 overrides port 0 on a collision.
          if (we1_ok) mem_q[Aw1] <= Dw1;
          if (clr_req) begin
            state_q  <= StClear;
            cnt_q    <= '0;
            clr_busy <= 1'b1;
          end
        end
        StClear: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            clr_busy <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    Dr = '0;
    for (int i = 0; i < int'(NREAD); i++) begin
      if (addr_ok(Ar[i*AW +: AW])) begin
        Dr[i*WIDTH +: WIDTH] = mem_q[Ar[i*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      if (we0_ok && (Ar[i*AW +: AW] == Aw0)) Dr[i*WIDTH +: WIDTH] = Dw0;
      if (we1_ok && (Ar[i*AW +: AW] == Aw1)) Dr[i*WIDTH +: WIDTH] = Dw1;
`endif
    end
  end

endmodule
